simon_sequence_player: RTL

//  Transmit side of the game's num/pressed button interface. It stores the game's step sequence and

---
 rtl/simon_sequence_player.sv | 133 +++++++++++++
 1 files changed

// File: rtl/simon_sequence_player.sv
// Simon step-sequence store and timed press/release player.
// Optional seed load ports enabled by SIMON_PLAYER_SEED_EN.
module simon_sequence_player #(
  parameter int MAX_LEN    = 32,
  parameter int ON_CYCLES  = 12_500_000,
  parameter int OFF_CYCLES = 5_000_000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       append,
  input  logic                       clear,
`ifdef SIMON_PLAYER_SEED_EN
  input  logic                       seed_load,
  input  logic [15:0]                seed,
`endif
  input  logic [$clog2(MAX_LEN)-1:0] rd_idx,
  output logic [1:0]                 rd_num,
  output logic [1:0]                 num,
  output logic                       pressed,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(MAX_LEN):0]   len,
  output logic                       full
);

  localparam int IW   = $clog2(MAX_LEN);
  localparam int LW   = IW + 1;
  localparam int MAXC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [15:0] SEED0 = 16'hACE1;

  typedef enum logic [1:0] {IDLE, ON, GAP, FIN} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [1:0]      num_q, num_d;
  logic [LW-1:0]   len_q, len_d;
  logic [15:0]     lfsr_q, lfsr_d;
  logic            we;
  logic [1:0]      seq_q [MAX_LEN];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      num_q   <= '0;
      len_q   <= '0;
      lfsr_q  <= SEED0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      num_q   <= num_d;
      len_q   <= len_d;
      lfsr_q  <= lfsr_d;
    end
  end

  // Sequence storage needs no reset; contents are only read below len.
  always_ff @(posedge clk) begin
    if (we) seq_q[len_q[IW-1:0]] <= lfsr_q[1:0];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    num_d   = num_q;
    len_d   = len_q;
    we      = 1'b0;
    if (lfsr_q == '0) lfsr_d = SEED0;
    else lfsr_d = {lfsr_q[14:0],
                   lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
`ifdef SIMON_PLAYER_SEED_EN
    if (seed_load) lfsr_d = (seed == '0) ? SEED0 : seed;
`endif
    unique case (state_q)
      IDLE: begin
        if (clear) begin
          len_d = '0;
        end else if (append) begin
          if (!full) begin
            we    = 1'b1;
            len_d = len_q + 1'b1;
          end
        end else if (start) begin
          if (len_q == '0) begin
            state_d = FIN;
          end else begin
            state_d = ON;
            idx_d   = '0;
            num_d   = seq_q[0];
            cnt_d   = CW'(ON_CYCLES - 1);
          end
        end
      end
      ON: begin
        if (cnt_q == '0) begin
          state_d = GAP;
          cnt_d   = CW'(OFF_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      GAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (({1'b0, idx_q} + 1'b1) == len_q) begin
          state_d = FIN;
        end else begin
          state_d = ON;
          idx_d   = idx_q + 1'b1;
          num_d   = seq_q[idx_q + 1'b1];
          cnt_d   = CW'(ON_CYCLES - 1);
        end
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign rd_num  = seq_q[rd_idx];
  assign num     = num_q;
  assign pressed = (state_q == ON);
  assign busy    = (state_q == ON) || (state_q == GAP);
  assign done    = (state_q == FIN);
  assign len     = len_q;
  assign full    = (len_q == LW'(MAX_LEN));

endmodule
